// File: rtl/traffic_control_if.sv
// Crossroad controller bus: mode select in, lamp drives and countdown out.
//   cases    : mode select (0 normal, 1 A priority, 2 B priority, 3 all red, 4-7 as 0)
//   A_lights : road A lamps, one-hot {red, yellow, green}
//   B_lights : road B lamps, same encoding
//   num_out  : remaining ticks in the current timed state, 0 in hold states
interface traffic_control_if;
    logic [2:0] cases;
    logic [2:0] A_lights;
    logic [2:0] B_lights;
    logic [3:0] num_out;

    modport master (
        output cases,
        input  A_lights,
        input  B_lights,
        input  num_out
    );

    modport slave (
        input  cases,
        output A_lights,
        output B_lights,
        output num_out
    );
endinterface

// File: rtl/traffic_control.sv
// Two-road crossroad light controller: fixed green/yellow cycle with a
// countdown display and A-priority, B-priority and all-red override modes.
// Ports:
//   clk   : system clock, one clock = one countdown tick
//   rst_a : asynchronous active-low reset (A green, count 9)
//   bus   : traffic_control_if slave (cases in; A_lights, B_lights, num_out out)
module traffic_control (
    input  logic               clk,
    input  logic               rst_a,
    traffic_control_if.slave   bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] GRN_LOAD = CNT_W'(9);
    localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(2);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        A_GRN   = 3'd0,
        A_YEL   = 3'd1,
        B_GRN   = 3'd2,
        B_YEL   = 3'd3,
        A_HOLD  = 3'd4,
        B_HOLD  = 3'd5,
        ALL_RED = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [1:0]       mode;
    logic             expired;
    logic [5:0]       lamps_nxt;

    // Lamp decode {A, B} for a given state.
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            A_GRN, A_HOLD: lamps = {GRN, RED};
            A_YEL:         lamps = {YEL, RED};
            B_GRN, B_HOLD: lamps = {RED, GRN};
            B_YEL:         lamps = {RED, YEL};
            default:       lamps = {RED, RED};
        endcase
    endfunction

    // Next-state and count logic.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mode      = bus.cases[2] ? 2'd0 : bus.cases[1:0];
        expired   = (count == CNT_W'(0));

        case (mode)
            2'd1: begin
                case (state)
                    A_GRN, A_YEL, ALL_RED: state_nxt = A_HOLD;
                    B_GRN, B_HOLD:         state_nxt = B_YEL;
                    B_YEL:                 if (expired) state_nxt = A_HOLD;
                    default:               state_nxt = state;
                endcase
            end
            2'd2: begin
                case (state)
                    B_GRN, B_YEL, ALL_RED: state_nxt = B_HOLD;
                    A_GRN, A_HOLD:         state_nxt = A_YEL;
                    A_YEL:                 if (expired) state_nxt = B_HOLD;
                    default:               state_nxt = state;
                endcase
            end
            2'd3: begin
                case (state)
                    A_GRN, A_HOLD: state_nxt = A_YEL;
                    B_GRN, B_HOLD: state_nxt = B_YEL;
                    A_YEL, B_YEL:  if (expired) state_nxt = ALL_RED;
                    default:       state_nxt = state;
                endcase
            end
            default: begin
                case (state)
                    A_GRN:           if (expired) state_nxt = A_YEL;
                    A_YEL:           if (expired) state_nxt = B_GRN;
                    B_GRN:           if (expired) state_nxt = B_YEL;
                    B_YEL:           if (expired) state_nxt = A_GRN;
                    B_HOLD:          state_nxt = B_GRN;
                    A_HOLD, ALL_RED: state_nxt = A_GRN;
                    default:         state_nxt = A_GRN;
                endcase
            end
        endcase

        // Any state entry reloads; staying in a timed state counts down.
        // Every timed state leaves on expiry, so the decrement never wraps.
        if (state_nxt != state) begin
            case (state_nxt)
                A_GRN, B_GRN: count_nxt = GRN_LOAD;
                A_YEL, B_YEL: count_nxt = YEL_LOAD;
                default:      count_nxt = CNT_W'(0);
            endcase
        end else if (state == A_GRN || state == A_YEL ||
                     state == B_GRN || state == B_YEL) begin
            count_nxt = count - CNT_W'(1);
        end

        lamps_nxt = lamps(state_nxt);
    end

    // State, count and lamp registers; lamps track the registered state.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state        <= A_GRN;
            count        <= GRN_LOAD;
            bus.A_lights <= GRN;
            bus.B_lights <= RED;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            bus.A_lights <= lamps_nxt[5:3];
            bus.B_lights <= lamps_nxt[2:0];
        end
    end

    assign bus.num_out = count;

endmodule

// File: tb/tb_traffic_control.sv
module tb_traffic_control;
    logic clk;
    logic rst_a;
    int   vectors;
    int   miscompares;

    traffic_control_if tif ();

    traffic_control dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset and release; leaves the DUT in A_GRN/9 before the first counting edge.
    task automatic do_reset();
        @(negedge clk);
        rst_a = 1'b0;
        #2;
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    // Expected {A, B, num} at position p of the 26-tick normal cycle.
    function automatic logic [9:0] norm_exp(input int p);
        if (p < 10)      norm_exp = {3'b001, 3'b100, 4'(9 - p)};
        else if (p < 13) norm_exp = {3'b010, 3'b100, 4'(12 - p)};
        else if (p < 23) norm_exp = {3'b100, 3'b001, 4'(22 - p)};
        else             norm_exp = {3'b100, 3'b010, 4'(25 - p)};
    endfunction

    task automatic test_reset();
        logic [9:0] got;
        tif.cases = 3'd0;
        rst_a     = 1'b1;
        #2;
        rst_a = 1'b0;
        #1;
        got = {tif.A_lights, tif.B_lights, tif.num_out};
        vectors++;
        if (got !== {3'b001, 3'b100, 4'd9}) begin
            miscompares++;
            $display("FAIL reset_async got=%b required=%b", got, {3'b001, 3'b100, 4'd9});
        end
        step(2);
        got = {tif.A_lights, tif.B_lights, tif.num_out};
        vectors++;
        if (got !== {3'b001, 3'b100, 4'd9}) begin
            miscompares++;
            $display("FAIL reset_held got=%b required=%b", got, {3'b001, 3'b100, 4'd9});
        end
        @(negedge clk);
        rst_a = 1'b1;
        step(1);
        vectors++;
        if (tif.num_out !== 4'd8) begin
            miscompares++;
            $display("FAIL reset_first_tick got=%0d required=8", tif.num_out);
        end
    endtask

    task automatic test_normal(input logic [2:0] mode);
        logic [9:0] got, exp;
        tif.cases = mode;
        do_reset();
        for (int e = 0; e <= 26; e++) begin
            if (e > 0) step(1);
            got = {tif.A_lights, tif.B_lights, tif.num_out};
            exp = norm_exp(e % 26);
            vectors++;
            if (got !== exp || (tif.A_lights != 3'b100 && tif.B_lights != 3'b100)) begin
                miscompares++;
                $display("FAIL normal_m%0d_e%0d got=%b required=%b", mode, e, got, exp);
            end
        end
    endtask

    task automatic test_a_priority();
        logic [9:0] got;
        logic [9:0] exp [8] = '{
            {3'b100, 3'b010, 4'd2}, {3'b100, 3'b010, 4'd1}, {3'b100, 3'b010, 4'd0},
            {3'b001, 3'b100, 4'd0}, {3'b001, 3'b100, 4'd0}, {3'b001, 3'b100, 4'd0},
            {3'b001, 3'b100, 4'd9}, {3'b001, 3'b100, 4'd8}};
        tif.cases = 3'd0;
        do_reset();
        step(13);
        tif.cases = 3'd1;
        for (int e = 0; e < 8; e++) begin
            if (e == 6) tif.cases = 3'd0;
            step(1);
            got = {tif.A_lights, tif.B_lights, tif.num_out};
            vectors++;
            if (got !== exp[e]) begin
                miscompares++;
                $display("FAIL a_priority_e%0d got=%b required=%b", e, got, exp[e]);
            end
        end
    endtask

    task automatic test_b_priority();
        logic [9:0] got;
        logic [9:0] exp [8] = '{
            {3'b010, 3'b100, 4'd2}, {3'b010, 3'b100, 4'd1}, {3'b010, 3'b100, 4'd0},
            {3'b100, 3'b001, 4'd0}, {3'b100, 3'b001, 4'd0}, {3'b100, 3'b001, 4'd0},
            {3'b100, 3'b001, 4'd9}, {3'b100, 3'b001, 4'd8}};
        tif.cases = 3'd0;
        do_reset();
        step(2);
        tif.cases = 3'd2;
        for (int e = 0; e < 8; e++) begin
            if (e == 6) tif.cases = 3'd0;
            step(1);
            got = {tif.A_lights, tif.B_lights, tif.num_out};
            vectors++;
            if (got !== exp[e]) begin
                miscompares++;
                $display("FAIL b_priority_e%0d got=%b required=%b", e, got, exp[e]);
            end
        end
    endtask

    task automatic test_all_red();
        logic [9:0] got;
        logic [9:0] exp [7] = '{
            {3'b100, 3'b010, 4'd2}, {3'b100, 3'b010, 4'd1}, {3'b100, 3'b010, 4'd0},
            {3'b100, 3'b100, 4'd0}, {3'b100, 3'b100, 4'd0},
            {3'b001, 3'b100, 4'd9}, {3'b001, 3'b100, 4'd8}};
        tif.cases = 3'd0;
        do_reset();
        step(15);
        tif.cases = 3'd3;
        for (int e = 0; e < 7; e++) begin
            if (e == 5) tif.cases = 3'd0;
            step(1);
            got = {tif.A_lights, tif.B_lights, tif.num_out};
            vectors++;
            if (got !== exp[e]) begin
                miscompares++;
                $display("FAIL all_red_e%0d got=%b required=%b", e, got, exp[e]);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        logic [9:0] got;
        tif.cases = 3'd0;
        do_reset();
        step(11);
        got = {tif.A_lights, tif.B_lights, tif.num_out};
        vectors++;
        if (got !== {3'b010, 3'b100, 4'd1}) begin
            miscompares++;
            $display("FAIL mid_yellow_pre got=%b required=%b", got, {3'b010, 3'b100, 4'd1});
        end
        #2;
        rst_a = 1'b0;
        #1;
        got = {tif.A_lights, tif.B_lights, tif.num_out};
        vectors++;
        if (got !== {3'b001, 3'b100, 4'd9}) begin
            miscompares++;
            $display("FAIL mid_yellow_reset got=%b required=%b", got, {3'b001, 3'b100, 4'd9});
        end
        @(negedge clk);
        rst_a = 1'b1;
        step(1);
        got = {tif.A_lights, tif.B_lights, tif.num_out};
        vectors++;
        if (got !== {3'b001, 3'b100, 4'd8}) begin
            miscompares++;
            $display("FAIL mid_yellow_release got=%b required=%b", got, {3'b001, 3'b100, 4'd8});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_a       = 1'b1;
        tif.cases   = 3'd0;
        test_reset();
        test_normal(3'd0);
        test_a_priority();
        test_b_priority();
        test_all_red();
        test_normal(3'd5);
        test_normal(3'd7);
        test_reset_mid_yellow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_control.md
# traffic_control

Two-road crossroad traffic-light controller for roads A and B. It runs a fixed green/yellow/red cycle with a 4-bit countdown for a display. It also supports three override modes selected by `cases`: A priority, B priority and all-red. It is a single-clock Moore FSM at the top of the crossroad design, driving lamp drivers and a digit display directly.

## Interface
- No parameters. Timing constants are fixed: green = 10 cycles (count 9..0), yellow = 3 cycles (count 2..0).
- `clk`  in  1  system clock; one clock = one countdown tick.
- `rst_a`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cases`  in  3  mode select. 0 = normal, 1 = A priority, 2 = B priority, 3 = all red, 4–7 = treated as 0.
- `A_lights`  out  3  road A lamps, one-hot {red, yellow, green}: 100 = red, 010 = yellow, 001 = green.
- `B_lights`  out  3  road B lamps, same encoding.
- `num_out`  out  4  remaining ticks in the current timed state; 0 in hold states.

## Operation
- The block holds two registers: `state` and a 4-bit `count`. `num_out` = `count`. Lights are decoded from `state` only.
- States and lamps:
  - A_GRN: A=001, B=100
  - A_YEL: A=010, B=100
  - B_GRN: A=100, B=001
  - B_YEL: A=100, B=010
  - A_HOLD: A=001, B=100
  - B_HOLD: A=100, B=001
  - ALL_RED: A=100, B=100
- Timed states (A_GRN, A_YEL, B_GRN, B_YEL): `count` decrements each edge. On the edge where `count` == 0, the FSM takes the expiry transition.
- Entering any green state loads 9. Entering any yellow state loads 2. Entering any hold or ALL_RED state loads 0.
- Invariant: at no time are both roads non-red. A green never goes directly to red; it always passes through its own yellow.
- Mode 0 (normal):
  - A_GRN → A_YEL → B_GRN → B_YEL → A_GRN, each on expiry.
  - A_HOLD → A_GRN (load 9) on the next edge.
  - B_HOLD → B_GRN (load 9) on the next edge.
  - ALL_RED → A_GRN (load 9) on the next edge.
- Mode 1 (A priority), evaluated each edge:
  - A_GRN, A_YEL and ALL_RED → A_HOLD.
  - B_GRN and B_HOLD → B_YEL (load 2). This terminates B green early.
  - B_YEL counts down, then → A_HOLD.
  - A_HOLD stays.
- Mode 2 (B priority): exact mirror of mode 1 with A and B swapped.
- Mode 3 (all red):
  - A_GRN and A_HOLD → A_YEL (load 2).
  - B_GRN and B_HOLD → B_YEL (load 2).
  - Any yellow counts down, then → ALL_RED.
  - ALL_RED stays.
- Mode changes take effect on the first rising edge where the new `cases` value is sampled. There is no debounce.

## Timing
- Reset (`rst_a` = 0, asynchronous): state = A_GRN, count = 9. Outputs immediately A=001, B=100, `num_out`=9. Held while `rst_a` = 0.
- Release is synchronous to the next `clk` rise. The first decrement (9 → 8) happens on the first rising edge after `rst_a` goes high.
- Normal cycle is 26 cycles: A green 10, A yellow 3, B green 10, B yellow 3.
- Lights and `num_out` change only on the rising `clk` edge, except under asynchronous reset.
- Latency from a mode change to the forced state is 1 edge if no yellow is needed. If a yellow is needed it is 1 + 3 edges.
- Reset mid-cycle or mid-override overrides everything and returns to A_GRN with count 9.
- `cases` values 4–7 must behave identically to 0.

## Test plan
- Reset: `rst_a`=0 → A=001, B=100, `num_out`=9 without a clock edge. Release, then after 1 edge `num_out`=8.
- Normal run (`cases`=0) for 26 edges after release:
  - A green for counts 9..0.
  - A yellow 010 for counts 2..0.
  - B green for counts 9..0.
  - B yellow for counts 2..0.
  - Back to A=001 with `num_out`=9. Both roads are never non-red together.
- `cases`=1 asserted during B_GRN:
  - Next edge: B=010, `num_out`=2.
  - After 3 edges: A=001, B=100, `num_out`=0, held while `cases`=1.
  - Return to 0: next edge A_GRN with `num_out`=9.
- `cases`=2 asserted during A_GRN:
  - A yellow for 3 edges, then B=001, A=100, `num_out`=0 held.
  - Return to 0: next edge B_GRN with `num_out`=9.
- `cases`=3 asserted during B_GRN:
  - B yellow for 3 edges, then A=B=100, `num_out`=0.
  - Return to 0: next edge A=001, `num_out`=9.
- `cases`=5 → identical trace to `cases`=0.
- `rst_a` pulsed low mid-yellow → immediately A=001, B=100, `num_out`=9.
